// File: rtl/mem_pkg.sv
// Shared types for the sized data memory: access-size encodings and clear FSM states.
package mem_pkg;

  localparam logic [1:0] ACCESS_BYTE    = 2'b00;
  localparam logic [1:0] ACCESS_HALF    = 2'b01;
  localparam logic [1:0] ACCESS_WORD    = 2'b10;
  localparam logic [1:0] ACCESS_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    SIZE_BYTE    = ACCESS_BYTE,
    SIZE_HALF    = ACCESS_HALF,
    SIZE_WORD    = ACCESS_WORD,
    SIZE_ILLEGAL = ACCESS_ILLEGAL
  } access_size_t;

  typedef enum logic {
    CLEAR,
    READY
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: merges store data into the old word, builds byte
// enables, extends load data and flags misaligned/illegal accesses.
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_extend,
  input  logic [31:0] write_data,
  input  logic [31:0] old_word,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en,
  output logic [31:0] load_value,
  output logic        misaligned
);

  access_size_t sz;
  logic [7:0]   lane_byte;
  logic [15:0]  lane_half;

  assign sz        = access_size_t'(size);
  assign lane_byte = old_word[{lane, 3'b000} +: 8];
  assign lane_half = lane[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    store_word = old_word;
    byte_en    = 4'b0000;
    load_value = 32'h0;
    misaligned = 1'b0;
    case (sz)
      SIZE_BYTE: begin
        store_word[{lane, 3'b000} +: 8] = write_data[7:0];
        byte_en    = 4'b0001 << lane;
        load_value = {{24{sign_extend & lane_byte[7]}}, lane_byte};
      end
      SIZE_HALF: begin
        misaligned = lane[0];
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_word[{lane[1], 4'b0000} +: 16] = write_data[15:0];
        load_value = {{16{sign_extend & lane_half[15]}}, lane_half};
      end
      SIZE_WORD: begin
        misaligned = |lane;
        byte_en    = 4'b1111;
        store_word = write_data;
        load_value = old_word;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// DEPTH x 32 data memory with sized loads/stores, fault detection, optional
// registered read and a post-reset hardware clear sweep.
module data_memory_sized
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH          = 1024,
  parameter  int unsigned READ_LATENCY   = 0,
  parameter  int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned ADDR_BITS      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic [1:0]           accessSize,
  input  logic                 signExtend,
  input  logic [31:0]          address,
  input  logic [31:0]          writeData,
  output logic [31:0]          readData,
  output logic                 misaligned,
  output logic                 outOfRange,
  output logic                 busy,
  input  logic [ADDR_BITS-1:0] dbgAddr,
  output logic [31:0]          dbgData
);

  localparam int unsigned HIGH_LSB = ADDR_BITS + 2;

  logic [31:0]          mem [DEPTH];
  mem_state_t           state;
  logic [ADDR_BITS-1:0] clear_idx;

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic [31:0]          old_word;
  logic [31:0]          store_word;
  logic [31:0]          load_value;
  logic [3:0]           byte_en;
  logic                 align_mis;
  logic                 active;
  logic                 mis_c;
  logic                 oor_c;
  logic                 fault;
  logic                 we;
  logic [31:0]          rd_c;

  assign busy     = (state == CLEAR);
  assign word_idx = address[ADDR_BITS+1:2];
  assign lane     = address[1:0];
  assign old_word = mem[word_idx];
  assign dbgData  = mem[dbgAddr];

  load_store_align u_align (
    .size        (accessSize),
    .lane        (lane),
    .sign_extend (signExtend),
    .write_data  (writeData),
    .old_word    (old_word),
    .store_word  (store_word),
    .byte_en     (byte_en),
    .load_value  (load_value),
    .misaligned  (align_mis)
  );

  // Flags and data are quiet while the clear sweep owns the array.
  assign active = (memRead | memWrite) & ~busy;
  assign oor_c  = active & (|address[31:HIGH_LSB]);
  assign mis_c  = active & align_mis;
  assign fault  = mis_c | oor_c;
  assign we     = memWrite & ~busy & ~fault;
  assign rd_c   = (memRead & ~busy & ~fault) ? load_value : 32'h0;

  // Clear sequencer: one word per cycle, then hand over to normal accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clear_idx <= '0;
    end else if (state == CLEAR) begin
      clear_idx <= clear_idx + ADDR_BITS'(1);
      if (clear_idx == ADDR_BITS'(DEPTH - 1)) state <= READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        mem[clear_idx] <= 32'h0;
      end else if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign readData   = rd_c;
      assign misaligned = mis_c;
      assign outOfRange = oor_c;
    end else begin : g_reg_read
      logic [31:0] rd_q;
      logic        mis_q;
      logic        oor_q;

      // Captures pre-write contents, so a same-cycle store is seen one access later.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q  <= 32'h0;
          mis_q <= 1'b0;
          oor_q <= 1'b0;
        end else begin
          rd_q  <= rd_c;
          mis_q <= mis_c;
          oor_q <= oor_c;
        end
      end

      assign readData   = rd_q;
      assign misaligned = mis_q;
      assign outOfRange = oor_q;
    end
  endgenerate

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the MIPS data memory, for the core and the IO mirror.
- Word array of DEPTH x 32 bits with byte, halfword and word accesses (sb/sh/sw, lb/lbu/lh/lhu/lw).
- Selectable combinational or registered read.
- Misalignment and out-of-range detection with write suppression.
- Hardware clear state machine that zeroes the array after reset.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 4. ADDR_BITS = clog2(DEPTH).
- READ_LATENCY, 0, 0 = combinational readData/flags; 1 = registered, valid one cycle after the access.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset via the CLEAR state; 0 = contents preserved across reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- memRead  input  1  load request this cycle
- memWrite  input  1  store request this cycle
- accessSize  input  2  00 byte, 01 half, 10 word, 11 illegal
- signExtend  input  1  1 = lb/lh sign-extend, 0 = lbu/lhu zero-extend; ignored for word
- address  input  32  byte address
- writeData  input  32  store data; byte uses [7:0], half uses [15:0]
- readData  output  32  load result, extended to 32 bits
- misaligned  output  1  current (or registered) access is misaligned or illegal size
- outOfRange  output  1  address beyond DEPTH words
- busy  output  1  clear in progress; accesses ignored
- dbgAddr  input  ADDR_BITS  debug/IO word index
- dbgData  output  32  combinational word at dbgAddr, always live

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- While reset=1:
  - state <= CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0).
  - clearIdx <= 0.
  - Registered readData/misaligned/outOfRange <= 0.
  - No array writes.
- CLEAR state (first cycle after reset release onward):
  - Writes 32'h0 to word clearIdx each cycle, then clearIdx++.
  - When clearIdx==DEPTH-1 is written, next state is READY.
  - Clear therefore takes exactly DEPTH cycles after reset falls.
  - busy=1 throughout; memRead/memWrite are ignored (no write, readData=0, flags=0).
  - Reset reasserted mid-clear restarts at index 0.
- READY state: busy=0.
- Word index = address[ADDR_BITS+1:2]; lane = address[1:0]; little-endian (lane 0 = bits [7:0]).
- outOfRange=1 when any of address[31:ADDR_BITS+2] is nonzero and (memRead|memWrite).
- misaligned=1 when (memRead|memWrite) and any of:
  - half with address[0]=1;
  - word with address[1:0]!=0;
  - accessSize=11.
- Faulted access (either flag set): store suppressed, readData=0.
- Store, byte: only lane address[1:0] updated with writeData[7:0]; other bytes unchanged.
- Store, half: bytes {address[1],1},{address[1],0} updated with writeData[15:0].
- Store, word: full word written.
- Load, byte: the byte at the lane, sign- or zero-extended per signExtend.
- Load, half: the half at address[1], sign- or zero-extended per signExtend.
- Load, word: the full word.
- memRead=0: readData=0 (latency 0); registered readData <= 0 (latency 1).
- memRead and memWrite together: write performed at the edge; readData returns pre-write contents (read-before-write) in both latency modes.
- READ_LATENCY=1: readData, misaligned and outOfRange registered from the cycle-N request and presented in cycle N+1, held until the next edge.
- Back-to-back reads are fully pipelined, one per cycle.
- dbgData is unaffected by faults and busy; during CLEAR it shows zeros as they are written.

Decomposition:
- Shared package mem_pkg holds:
  - ACCESS_BYTE/ACCESS_HALF/ACCESS_WORD constants and an access_size_t enum (2 bits);
  - mem_state_t enum {CLEAR, READY}.
- One natural sub-module, load_store_align:
  - purely combinational;
  - from size, lane, signExtend, writeData and the old word, produces merged store word, byte-enable mask, extended load value and misaligned.
- The top module owns the array, the clear FSM and the latency register.

Test Plan:
- Clear: DEPTH=16, CLEAR_ON_RESET=1; preload word 5=32'hDEADBEEF, pulse reset -> busy=1 for exactly 16 cycles after reset falls, then dbgData at 5 reads 32'h0; memWrite during busy is not stored.
- Byte/half stores: word 0=32'h11223344; sb 8'hAA @addr 2 -> word 32'h11AA3344; sh 16'hBEEF @addr 0 -> 32'h11AABEEF.
- Loads: word 32'h80FF7F01; lb @3 -> 32'hFFFFFF80; lbu @3 -> 32'h00000080; lh @2 -> 32'hFFFF80FF; lhu @0 -> 32'h00007F01.
- Faults: sw @addr 6 -> misaligned=1, memory unchanged, readData=0; lw @32'h00001000 with DEPTH=1024 -> outOfRange=1; accessSize=11 -> misaligned=1.
- READ_LATENCY=1: lw @0,4,8 on consecutive cycles -> data appears cycles 1,2,3 in order; same-cycle sw 32'h5 + lw @0 (old 32'h7) -> readData 32'h7 next cycle, then 32'h5.
- CLEAR_ON_RESET=0: word 3=32'hCAFEF00D, reset pulse -> busy never asserts, word 3 still 32'hCAFEF00D.
